ans_state_renormalizer: RTL and testbench

Control stage directly upstream of the ANS symbol decoder. It owns the decoder state register and loads the initial state from the compressed byte stream. It drives `current_state` to the decoder and captures the decoder's symbol and next state. It then renormalizes the state by shifting in stream bytes until the state reaches `L_BOUND`, and hands each symbol downstream on a valid/ready interface.

---
 rtl/ans_pkg.sv | 23 ++
 rtl/ans_byte_shifter.sv | 43 ++++
 rtl/ans_state_renormalizer.sv | 212 +++++++++++++++++++++
 tb/tb_ans_state_renormalizer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ans_pkg.sv
// Shared ANS types and constants: decoder state/symbol typedefs, renormalizer FSM states.
// No logic; the default widths here also set the renormalizer's parameter defaults.
// No backpressure; declarations only.
package ans_pkg;

    localparam int ANS_STATE_WIDTH  = 32;
    localparam int ANS_SYMBOL_WIDTH = 4;
    localparam int STATE_BYTES      = ANS_STATE_WIDTH / 8;

    typedef logic [ANS_STATE_WIDTH-1:0]  ans_state_t;
    typedef logic [ANS_SYMBOL_WIDTH-1:0] ans_symbol_t;

    localparam ans_state_t L_BOUND = ans_state_t'(1) << (ANS_STATE_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DECODE,
        RENORM,
        EMIT
    } ans_renorm_state_t;

endpackage

// File: rtl/ans_byte_shifter.sv
// ANS state register with MSB-first byte shift-in, byte counter and lower-bound compare.
// State updates on the clock edge after shift_en or load_en; compare is combinational.
// No backpressure of its own; the owner decides when a byte is accepted.
module ans_byte_shifter #(
    parameter int                    STATE_WIDTH = 32,
    parameter int                    CNT_WIDTH   = 3,
    parameter logic [STATE_WIDTH-1:0] L_BOUND    = {1'b1, {(STATE_WIDTH-1){1'b0}}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   shift_en,
    input  logic                   load_en,
    input  logic [STATE_WIDTH-1:0] load_value,
    input  logic                   cnt_clr,
    input  logic [7:0]             byte_data,
    output logic [STATE_WIDTH-1:0] state,
    output logic [CNT_WIDTH-1:0]   byte_cnt,
    output logic [STATE_WIDTH-1:0] shifted,
    output logic                   shifted_ge
);

    assign shifted    = {state[STATE_WIDTH-9:0], byte_data};
    assign shifted_ge = (shifted >= L_BOUND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= '0;
            byte_cnt <= '0;
        end else begin
            if (load_en) begin
                state <= load_value;
            end else if (shift_en) begin
                state <= shifted;
            end
            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (shift_en) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ans_state_renormalizer.sv
// ANS decoder state owner: loads the initial state, captures decoder results, renormalizes, emits symbols.
// Per symbol: 1 cycle DECODE + 1 cycle per renorm byte + 1 cycle EMIT when unstalled.
// byte_valid low stalls INIT/RENORM; sym_ready low holds EMIT. Optional stats: ANS_RENORM_STATS_EN.
module ans_state_renormalizer #(
    parameter int                     STATE_WIDTH  = ans_pkg::ANS_STATE_WIDTH,
    parameter int                     SYMBOL_WIDTH = ans_pkg::ANS_SYMBOL_WIDTH,
    parameter int                     COUNT_WIDTH  = 16,
    parameter logic [STATE_WIDTH-1:0] L_BOUND      = {1'b1, {(STATE_WIDTH-1){1'b0}}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  num_symbols,
    input  logic                    byte_valid,
    input  logic [7:0]              byte_data,
    output logic                    byte_ready,
    output logic [STATE_WIDTH-1:0]  current_state,
    input  logic [SYMBOL_WIDTH-1:0] dec_symbol,
    input  logic [STATE_WIDTH-1:0]  dec_next_state,
    input  logic                    dec_valid,
    output logic                    sym_valid,
    output logic [SYMBOL_WIDTH-1:0] sym_data,
    input  logic                    sym_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
`ifdef ANS_RENORM_STATS_EN
    ,
    output logic [31:0]             stat_bytes,
    output logic [3:0]              stat_max_renorm
`endif
);

    import ans_pkg::*;

    localparam int NBYTES = STATE_WIDTH / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    ans_renorm_state_t fsm_q, fsm_d;

    logic [COUNT_WIDTH-1:0]  count_q;
    logic [SYMBOL_WIDTH-1:0] sym_data_q;
    logic                    done_q, error_q;

    logic                    shift_en, load_en, cnt_clr;
    logic                    done_d, err_set, start_acc, capture, count_dec;
    logic [CNT_W-1:0]        byte_cnt;
    logic [STATE_WIDTH-1:0]  shifted;
    logic                    shifted_ge;
    logic                    dec_ge;
    logic                    last_byte;

    ans_byte_shifter #(
        .STATE_WIDTH (STATE_WIDTH),
        .CNT_WIDTH   (CNT_W),
        .L_BOUND     (L_BOUND)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .load_en    (load_en),
        .load_value (dec_next_state),
        .cnt_clr    (cnt_clr),
        .byte_data  (byte_data),
        .state      (current_state),
        .byte_cnt   (byte_cnt),
        .shifted    (shifted),
        .shifted_ge (shifted_ge)
    );

    assign dec_ge    = (dec_next_state >= L_BOUND);
    assign last_byte = (byte_cnt == CNT_W'(NBYTES - 1));

    always_comb begin
        fsm_d      = fsm_q;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        cnt_clr    = 1'b0;
        done_d     = 1'b0;
        err_set    = 1'b0;
        start_acc  = 1'b0;
        capture    = 1'b0;
        count_dec  = 1'b0;
        byte_ready = 1'b0;
        sym_valid  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (num_symbols != '0) begin
                        fsm_d   = INIT;
                        cnt_clr = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            INIT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    shift_en = 1'b1;
                    if (last_byte) begin
                        if (shifted_ge) begin
                            fsm_d = DECODE;
                        end else begin
                            err_set = 1'b1;
                            done_d  = 1'b1;
                            fsm_d   = IDLE;
                        end
                    end
                end
            end
            DECODE: begin
                load_en = 1'b1;
                capture = 1'b1;
                if (!dec_valid) begin
                    err_set = 1'b1;
                    done_d  = 1'b1;
                    fsm_d   = IDLE;
                end else if (dec_ge) begin
                    fsm_d = EMIT;
                end else begin
                    fsm_d   = RENORM;
                    cnt_clr = 1'b1;
                end
            end
            RENORM: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    shift_en = 1'b1;
                    if (shifted_ge) begin
                        fsm_d = EMIT;
                    end else if (last_byte) begin
                        // A full state's worth of bytes could not lift it: stream is corrupt.
                        err_set = 1'b1;
                        done_d  = 1'b1;
                        fsm_d   = IDLE;
                    end
                end
            end
            EMIT: begin
                sym_valid = 1'b1;
                if (sym_ready) begin
                    count_dec = 1'b1;
                    if (count_q == COUNT_WIDTH'(1)) begin
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else begin
                        fsm_d = DECODE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            count_q    <= '0;
            sym_data_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            done_q <= done_d;
            if (start_acc && num_symbols != '0) begin
                count_q <= num_symbols;
            end else if (count_dec) begin
                count_q <= count_q - 1'b1;
            end
            if (capture) begin
                sym_data_q <= dec_symbol;
            end
            if (start_acc) begin
                error_q <= 1'b0;
            end else if (err_set) begin
                error_q <= 1'b1;
            end
        end
    end

    assign sym_data = sym_data_q;
    assign done     = done_q;
    assign error    = error_q;
    assign busy     = (fsm_q != IDLE);

`ifdef ANS_RENORM_STATS_EN
    logic [3:0] renorm_n;
    assign renorm_n = 4'(byte_cnt) + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_bytes      <= '0;
            stat_max_renorm <= '0;
        end else if (start_acc) begin
            stat_bytes      <= '0;
            stat_max_renorm <= '0;
        end else begin
            if (shift_en && stat_bytes != '1) begin
                stat_bytes <= stat_bytes + 32'd1;
            end
            if (fsm_q == RENORM && shift_en && renorm_n > stat_max_renorm) begin
                stat_max_renorm <= renorm_n;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ans_state_renormalizer.sv
// Directed bench for ans_state_renormalizer: init load, renorm, stalls, errors, empty block, reset, multi-symbol.
module tb_ans_state_renormalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_symbols;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] current_state;
    logic [3:0]  dec_symbol;
    logic [31:0] dec_next_state;
    logic        dec_valid;
    logic        sym_valid;
    logic [3:0]  sym_data;
    logic        sym_ready;
    logic        busy;
    logic        done;
    logic        error;
`ifdef ANS_RENORM_STATS_EN
    logic [31:0] stat_bytes;
    logic [3:0]  stat_max_renorm;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ans_state_renormalizer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_symbols    (num_symbols),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .current_state  (current_state),
        .dec_symbol     (dec_symbol),
        .dec_next_state (dec_next_state),
        .dec_valid      (dec_valid),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_ready      (sym_ready),
        .busy           (busy),
        .done           (done),
        .error          (error)
`ifdef ANS_RENORM_STATS_EN
        ,
        .stat_bytes      (stat_bytes),
        .stat_max_renorm (stat_max_renorm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then stable and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input logic [31:0] word);
        for (int i = 3; i >= 0; i--) begin
            byte_valid = 1'b1;
            byte_data  = word[i*8 +: 8];
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] n);
        start       = 1'b1;
        num_symbols = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        num_symbols    = '0;
        byte_valid     = 1'b0;
        byte_data      = '0;
        dec_symbol     = '0;
        dec_next_state = '0;
        dec_valid      = 1'b0;
        sym_ready      = 1'b0;
        tick();
        tick();
        chk("rst_state", current_state, 32'h0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym_data", 32'(sym_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Init with no renorm
        do_start(16'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_init_ready", 32'(byte_ready), 32'd1);
        send_bytes(32'h8000_0005);
        chk("t1_init_state", current_state, 32'h8000_0005);
        chk("t1_decode_ready", 32'(byte_ready), 32'd0);
        dec_next_state = 32'h8000_1000;
        dec_symbol     = 4'd3;
        dec_valid      = 1'b1;
        tick();
        chk("t1_emit_valid", 32'(sym_valid), 32'd1);
        chk("t1_sym", 32'(sym_data), 32'd3);
        chk("t1_state", current_state, 32'h8000_1000);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Two-byte renorm with byte and sym stalls
        do_start(16'd1);
        send_bytes(32'h8000_0005);
        dec_next_state = 32'h0000_8000;
        dec_symbol     = 4'd7;
        tick();
        chk("t2_renorm_state", current_state, 32'h0000_8000);
        chk("t2_renorm_ready", 32'(byte_ready), 32'd1);
        tick();
        chk("t2_stall0", current_state, 32'h0000_8000);
        byte_valid = 1'b1;
        byte_data  = 8'hAB;
        tick();
        byte_valid = 1'b0;
        chk("t2_byte1", current_state, 32'h0080_00AB);
        chk("t2_no_emit_yet", 32'(sym_valid), 32'd0);
        tick();
        chk("t2_stall1", current_state, 32'h0080_00AB);
        byte_valid = 1'b1;
        byte_data  = 8'hCD;
        tick();
        chk("t2_byte2", current_state, 32'h8000_ABCD);
        chk("t2_emit", 32'(sym_valid), 32'd1);
        byte_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_sym", 32'(sym_data), 32'd7);
            chk("t2_hold_state", current_state, 32'h8000_ABCD);
            chk("t2_hold_no_done", 32'(done), 32'd0);
            chk("t2_emit_no_byte", 32'(byte_ready), 32'd0);
            tick();
        end
        byte_valid = 1'b0;
        chk("t2_still_valid", 32'(sym_valid), 32'd1);
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_error", 32'(error), 32'd0);

        // Decoder reports invalid symbol
        do_start(16'd2);
        send_bytes(32'h8000_0001);
        dec_valid = 1'b0;
        tick();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);
        tick();
        chk("t3_error_sticky", 32'(error), 32'd1);
        chk("t3_done_pulse", 32'(done), 32'd0);

        // Renorm exhausts a full state of zero bytes
        do_start(16'd1);
        chk("t4_error_cleared", 32'(error), 32'd0);
        send_bytes(32'h8000_0000);
        dec_valid      = 1'b1;
        dec_next_state = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'h00;
            tick();
        end
        chk("t4_still_renorm", 32'(byte_ready), 32'd1);
        chk("t4_no_err_yet", 32'(error), 32'd0);
        tick();
        byte_valid = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);

        // Initial state below the bound
        do_start(16'd1);
        send_bytes(32'h1234_5678);
        chk("t4b_done", 32'(done), 32'd1);
        chk("t4b_error", 32'(error), 32'd1);
        chk("t4b_state", current_state, 32'h1234_5678);

        // Empty block
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        do_start(16'd0);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_no_byte", 32'(byte_ready), 32'd0);
        chk("t5_state_kept", current_state, 32'h1234_5678);
        tick();
        byte_valid = 1'b0;
        chk("t5_done_pulse", 32'(done), 32'd0);

        // Reset during renorm
        do_start(16'd1);
        send_bytes(32'h8000_0000);
        dec_next_state = 32'h0000_0100;
        tick();
        byte_valid = 1'b1;
        byte_data  = 8'h11;
        tick();
        byte_valid = 1'b0;
        chk("t6_renorm_state", current_state, 32'h0001_0011);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_state", current_state, 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(byte_ready), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_after_busy", 32'(busy), 32'd0);
        chk("t6_after_done", 32'(done), 32'd0);

        // Three symbols with an ignored start mid-block
        do_start(16'd3);
        send_bytes(32'h8000_0000);
        for (int s = 0; s < 3; s++) begin
            dec_next_state = 32'h9000_0000 + 32'(s);
            dec_symbol     = 4'(s + 1);
            dec_valid      = 1'b1;
            tick();
            chk("t7_emit", 32'(sym_valid), 32'd1);
            chk("t7_sym", 32'(sym_data), 32'(s + 1));
            chk("t7_state", current_state, 32'h9000_0000 + 32'(s));
            if (s == 0) begin
                start       = 1'b1;
                num_symbols = 16'd5;
                tick();
                start = 1'b0;
                chk("t7_start_ignored", 32'(sym_valid), 32'd1);
            end
            sym_ready = 1'b1;
            tick();
            sym_ready = 1'b0;
            chk("t7_done", 32'(done), (s == 2) ? 32'd1 : 32'd0);
            chk("t7_busy", 32'(busy), (s == 2) ? 32'd0 : 32'd1);
        end
        chk("t7_error", 32'(error), 32'd0);
        tick();
        chk("t7_done_pulse", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
